// File: rtl/divrec_pkg.sv
// Shared types and constants for the sequential dividend reconstructor.
package divrec_pkg;

  localparam int W_DEF = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_ADD  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    MUL  = ST_MUL,
    ADD  = ST_ADD,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/divrec_step.sv
// One shift-and-add step: acc_next = acc + (bit ? operand << cnt : 0), zero-extended to 2W.
module divrec_step
  import divrec_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = 2
) (
  input  logic [2*W-1:0] acc_i,
  input  logic [W-1:0]   br_i,
  input  logic           bit_i,
  input  logic [CW-1:0]  cnt_i,
  output logic [2*W-1:0] acc_next_o
);

  logic [2*W-1:0] addend;

  always_comb begin
    addend = '0;
    if (bit_i) begin
      addend = {{W{1'b0}}, br_i} << cnt_i;
    end
    acc_next_o = acc_i + addend;
  end

endmodule

// File: rtl/divrec_seq.sv
// Sequential a = q*b + r with illegal-remainder flag; W multiply cycles, one add cycle,
// then a DONE cycle whose registered results appear together with the done pulse.
module divrec_seq
  import divrec_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   q,
  input  logic [W-1:0]   b,
  input  logic [W-1:0]   r,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] a,
  output logic           rem_err
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_t         state_q, state_d;
  logic [W-1:0]   qr_q, qr_d, br_q, br_d, rr_q, rr_d;
  logic [2*W-1:0] acc_q, acc_d, a_q, a_d, step_acc;
  logic [CW-1:0]  cnt_q, cnt_d, step_cnt;
  logic [W-1:0]   step_br;
  logic           step_bit, load;
  logic           err_q, err_d, rem_err_q, rem_err_d, done_q, done_d;

  divrec_step #(.W(W), .CW(CW)) u_step (
    .acc_i      (acc_q),
    .br_i       (step_br),
    .bit_i      (step_bit),
    .cnt_i      (step_cnt),
    .acc_next_o (step_acc)
  );

  always_comb begin
    state_d   = state_q;
    qr_d      = qr_q;
    br_d      = br_q;
    rr_d      = rr_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    a_d       = a_q;
    rem_err_d = rem_err_q;
    done_d    = 1'b0;
    load      = 1'b0;
    step_br   = br_q;
    step_bit  = qr_q[cnt_q];
    step_cnt  = cnt_q;
    case (state_q)
      IDLE: load = start;
      MUL: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) state_d = ADD;
      end
      ADD: begin
        // Remainder add reuses the step adder as an unshifted, always-taken term.
        step_br  = rr_q;
        step_bit = 1'b1;
        step_cnt = '0;
        acc_d    = step_acc;
        err_d    = (rr_q >= br_q);
        state_d  = DONE;
      end
      DONE: begin
        done_d    = 1'b1;
        a_d       = acc_q;
        rem_err_d = err_q;
        state_d   = IDLE;
        load      = start;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      qr_d    = q;
      br_d    = b;
      rr_d    = r;
      acc_d   = '0;
      cnt_d   = '0;
      state_d = MUL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      qr_q      <= '0;
      br_q      <= '0;
      rr_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      a_q       <= '0;
      rem_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      qr_q      <= qr_d;
      br_q      <= br_d;
      rr_q      <= rr_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      a_q       <= a_d;
      rem_err_q <= rem_err_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q == MUL) || (state_q == ADD);
  assign done    = done_q;
  assign a       = a_q;
  assign rem_err = rem_err_q;

endmodule
